// File: rtl/body_hit_pkg.sv
// body_hit_pkg: shared defaults, coordinate type and width helpers for the body hit table.
package body_hit_pkg;
    localparam int DEF_DEPTH = 20;
    localparam int DEF_XW = 6;
    localparam int DEF_YW = 6;
    typedef struct packed {
        logic [DEF_XW-1:0] x;
        logic [DEF_YW-1:0] y;
    } coord_t;
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/body_hit_match.sv
// body_hit_match: DEPTH-wide coordinate compare gated by per-entry live bits.
module body_hit_match #(
    parameter int DEPTH = 20,
    parameter int XW = 6,
    parameter int YW = 6
) (
    input  logic [DEPTH-1:0][XW-1:0] x_i,
    input  logic [DEPTH-1:0][YW-1:0] y_i,
    input  logic [DEPTH-1:0]         live_i,
    input  logic [XW-1:0]            q_x_i,
    input  logic [YW-1:0]            q_y_i,
    output logic [DEPTH-1:0]         match_o
);
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match_o[i] = live_i[i] && x_i[i] == q_x_i && y_i[i] == q_y_i;
    end
endmodule

// File: rtl/body_hit_table.sv
// body_hit_table: ring-buffered coordinate table with registered 1-cycle hit query.
// Define HIT_IDX_EN to add the r_idx port reporting the oldest matching entry's age.
module body_hit_table
    import body_hit_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int XW = DEF_XW,
    parameter int YW = DEF_YW,
    localparam int IDXW = idx_w(DEPTH),
    localparam int CNTW = cnt_w(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            push,
    input  logic [XW-1:0]   push_x,
    input  logic [YW-1:0]   push_y,
    input  logic            pop,
    input  logic            q_valid,
    input  logic [XW-1:0]   q_x,
    input  logic [YW-1:0]   q_y,
    output logic            r_valid,
    output logic            r_hit,
`ifdef HIT_IDX_EN
    output logic [IDXW-1:0] r_idx,
`endif
    output logic [CNTW-1:0] count,
    output logic            full,
    output logic            empty,
    output logic            drop
);
    logic [DEPTH-1:0][XW-1:0] x_q;
    logic [DEPTH-1:0][YW-1:0] y_q;
    logic [DEPTH-1:0]         live_q, live_d, match;
    logic [IDXW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CNTW-1:0]          count_q, count_d;
    logic                     drop_q, drop_d, r_valid_q, r_hit_q, r_hit_d;
    logic                     do_push, do_pop;

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] p);
        return p == IDXW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    body_hit_match #(.DEPTH(DEPTH), .XW(XW), .YW(YW)) u_match (
        .x_i(x_q),
        .y_i(y_q),
        .live_i(live_q),
        .q_x_i(q_x),
        .q_y_i(q_y),
        .match_o(match)
    );

    // A full table still accepts push when a pop frees the oldest slot in the same cycle.
    assign do_pop  = pop && count_q != '0;
    assign do_push = push && (count_q != CNTW'(DEPTH) || do_pop);

    always_comb begin
        live_d = live_q;
        if (do_pop) live_d[tail_q] = 1'b0;
        if (do_push) live_d[head_q] = 1'b1;
        if (clr) live_d = '0;
    end

    assign head_d  = clr ? '0 : do_push ? wrap_inc(head_q) : head_q;
    assign tail_d  = clr ? '0 : do_pop ? wrap_inc(tail_q) : tail_q;
    assign count_d = clr ? '0 : count_q + CNTW'(do_push) - CNTW'(do_pop);
    assign drop_d  = !clr && ((push && !do_push) || (pop && !do_pop));
    assign r_hit_d = q_valid ? |match : r_hit_q;

`ifdef HIT_IDX_EN
    logic [DEPTH-1:0] aged;
    logic [IDXW-1:0]  first, r_idx_q, r_idx_d;
    // Rotate so bit k is the entry of age k, then pick the lowest set bit.
    assign aged = DEPTH'({match, match} >> tail_q);
    always_comb begin
        first = '0;
        for (int k = DEPTH - 1; k >= 0; k--) if (aged[k]) first = IDXW'(k);
    end
    assign r_idx_d = q_valid ? first : r_idx_q;
    assign r_idx = r_idx_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_idx_q <= '0;
        else r_idx_q <= r_idx_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            x_q[head_q] <= push_x;
            y_q[head_q] <= push_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            drop_q    <= 1'b0;
            r_valid_q <= 1'b0;
            r_hit_q   <= 1'b0;
        end else begin
            live_q    <= live_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
            r_valid_q <= q_valid;
            r_hit_q   <= r_hit_d;
        end
    end

    assign count   = count_q;
    assign full    = count_q == CNTW'(DEPTH);
    assign empty   = count_q == '0;
    assign drop    = drop_q;
    assign r_valid = r_valid_q;
    assign r_hit   = r_hit_q;
endmodule
